icache_ctrl: RTL
================

Name: icache_ctrl

Overview:
- Sequencer and arbiter in front of the instruction memory (single addr/wen/wdata port, combinational read, synchronous write).
- Boot phase: streams program words from a host loader into consecutive memory addresses starting at 0.
- Run phase: hands the port to the CPU fetch stage and returns a registered fetch response one cycle after grant.
- Sits between the core's IF stage, the host/UART loader and the instruction memory.

Parameters:
- ADDR_WIDTH, 8, memory word-address width.
- ADDR_NUM, 256, number of 32-bit words; must equal 2**ADDR_WIDTH.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- boot_start  input  1  single-cycle request to (re)enter load phase
- ld_valid  input  1  loader word valid
- ld_ready  output  1  controller accepts loader word
- ld_data  input  32  loader word
- ld_last  input  1  marks final word of image (qualified by ld_valid)
- fetch_req  input  1  CPU fetch request
- fetch_addr  input  ADDR_WIDTH  CPU fetch word address
- fetch_gnt  output  1  fetch accepted this cycle
- fetch_rvalid  output  1  fetch_rdata valid (one cycle after gnt)
- fetch_rdata  output  32  registered fetch data
- mem_addr  output  ADDR_WIDTH  memory address
- mem_wen  output  1  memory write enable
- mem_wdata  output  32  memory write data
- mem_rdata  input  32  memory combinational read data
- busy  output  1  high while in LOAD
- load_done  output  1  one-cycle pulse on LOAD->RUN
- load_cnt  output  ADDR_WIDTH+1  words written in current/last load
- load_csum  output  32  see Optional Feature

Behaviour:
- Reset (rst_n low, async): state=IDLE, write pointer=0, load_cnt=0, fetch_rdata=0, fetch_rvalid=0, load_done=0, load_csum=0; all combinational outputs evaluate to 0 in IDLE.
- States: IDLE, LOAD, RUN.
- IDLE: ld_ready=0, fetch_gnt=0, mem_wen=0, mem_addr=0. On boot_start -> LOAD.
- Entering LOAD (from IDLE or RUN): pointer<=0, load_cnt<=0.
- LOAD: ld_ready=1, busy=1, fetch_gnt=0, mem_addr=pointer, mem_wdata=ld_data, mem_wen=ld_valid. Each handshake (ld_valid&&ld_ready) writes the word, pointer++, load_cnt++.
- LOAD exit: -> RUN when a handshake has ld_last=1, or when the word written is at pointer==ADDR_NUM-1. The pointer never wraps. load_done pulses in the first RUN cycle.
- boot_start is ignored in LOAD.
- RUN: ld_ready=0, mem_wen=0, mem_addr=fetch_addr, fetch_gnt=fetch_req.
  - On gnt, fetch_rdata<=mem_rdata and fetch_rvalid<=1 at the next edge; otherwise fetch_rvalid<=0 and fetch_rdata holds.
  - Back-to-back requests give one response per cycle.
  - The last LOAD write has already committed at the transition edge, so a fetch in the first RUN cycle sees it.
- boot_start in RUN -> LOAD next cycle. A fetch granted in the same cycle as boot_start still completes (rvalid next cycle). No grants are issued in LOAD.
- mem_wdata=0 whenever the state is not LOAD.
- A reset mid-LOAD abandons the load: state IDLE, partial contents stay in memory, load_cnt=0.
- Write and fetch can never be issued in the same cycle.

Optional Feature:
- Macro: ICACHE_CTRL_LOAD_CSUM_EN.
- Defined: load_csum is a 32-bit wrapping sum of every word written in the current load. It is cleared on entering LOAD and holds through RUN.
- Undefined: no accumulator; load_csum is tied to 0.

Decomposition:
- Shared package icache_ctrl_pkg holds:
  - state encoding constants (IDLE=2'd0, LOAD=2'd1, RUN=2'd2);
  - default ADDR_WIDTH/ADDR_NUM;
  - checksum width.
- No sub-module required. The optional accumulator stays inline under the macro.

Test Plan:
- Reset then boot_start; stream 4 words 0x11,0x22,0x33,0x44 with ld_last on the 4th -> mem writes at addr 0..3, load_done pulse, load_cnt=4, busy falls.
- RUN: fetch_req with addr 2 -> fetch_gnt same cycle, next cycle fetch_rvalid=1 and fetch_rdata=0x33. Back-to-back addr 0,1,3 -> rdata 0x11,0x22,0x44 on consecutive cycles.
- Load with ld_valid gaps (valid 1,0,0,1) -> only 2 writes, pointer advances only on handshake; fetch_req during LOAD -> fetch_gnt=0.
- Full load of 256 words without ld_last -> RUN after the write to addr 255, load_cnt=256, no write to addr 0 again.
- boot_start in RUN together with fetch_req addr 1 -> rvalid next cycle with old data, then LOAD with pointer 0. Assert rst_n low mid-load after 3 words -> state IDLE, outputs 0 immediately (async).
- With ICACHE_CTRL_LOAD_CSUM_EN: load 0xFFFFFFFF,0x2 -> load_csum=0x1 (wrap). Without the macro -> load_csum=0.

Source files
------------

// File: rtl/icache_ctrl_pkg.sv
// Shared constants and state encoding for the instruction-memory sequencer/arbiter.
package icache_ctrl_pkg;

  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_ADDR_NUM   = 256;
  localparam int CSUM_WIDTH     = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

endpackage

// File: rtl/icache_ctrl.sv
// Boot-loader / fetch arbiter in front of a single-port instruction memory.
// Optional load checksum enabled by defining ICACHE_CTRL_LOAD_CSUM_EN.
module icache_ctrl
  import icache_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int ADDR_NUM   = DEF_ADDR_NUM
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  boot_start,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [31:0]           ld_data,
  input  logic                  ld_last,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic                  fetch_gnt,
  output logic                  fetch_rvalid,
  output logic [31:0]           fetch_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_wen,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  output logic                  busy,
  output logic                  load_done,
  output logic [ADDR_WIDTH:0]   load_cnt,
  output logic [CSUM_WIDTH-1:0] load_csum
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(ADDR_NUM - 1);

  state_e                r_state;
  state_e                w_state_next;
  logic [ADDR_WIDTH-1:0] r_ptr;
  logic [ADDR_WIDTH:0]   r_load_cnt;
  logic                  r_load_done;
  logic                  r_fetch_rvalid;
  logic [31:0]           r_fetch_rdata;
  logic                  w_ld_hs;
  logic                  w_ld_exit;
  logic                  w_enter_load;

  always_comb begin
    w_state_next = r_state;
    ld_ready     = 1'b0;
    busy         = 1'b0;
    fetch_gnt    = 1'b0;
    mem_addr     = '0;
    mem_wen      = 1'b0;
    mem_wdata    = '0;
    w_ld_hs      = 1'b0;
    w_ld_exit    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (boot_start) w_state_next = ST_LOAD;
      end
      ST_LOAD: begin
        ld_ready  = 1'b1;
        busy      = 1'b1;
        mem_addr  = r_ptr;
        mem_wdata = ld_data;
        mem_wen   = ld_valid;
        w_ld_hs   = ld_valid;
        // The write at the top address ends the load so the pointer never wraps.
        if (w_ld_hs && (ld_last || (r_ptr == LAST_ADDR))) begin
          w_ld_exit    = 1'b1;
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        mem_addr  = fetch_addr;
        fetch_gnt = fetch_req;
        if (boot_start) w_state_next = ST_LOAD;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign w_enter_load = (r_state != ST_LOAD) && (w_state_next == ST_LOAD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_ptr          <= '0;
      r_load_cnt     <= '0;
      r_load_done    <= 1'b0;
      r_fetch_rvalid <= 1'b0;
      r_fetch_rdata  <= '0;
    end else begin
      r_state        <= w_state_next;
      r_load_done    <= w_ld_exit;
      r_fetch_rvalid <= fetch_gnt;
      if (fetch_gnt) r_fetch_rdata <= mem_rdata;
      if (w_enter_load) begin
        r_ptr      <= '0;
        r_load_cnt <= '0;
      end else if (w_ld_hs) begin
        r_load_cnt <= r_load_cnt + 1'b1;
        if (r_ptr != LAST_ADDR) r_ptr <= r_ptr + 1'b1;
      end
    end
  end

`ifdef ICACHE_CTRL_LOAD_CSUM_EN
  logic [CSUM_WIDTH-1:0] r_csum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_csum <= '0;
    end else if (w_enter_load) begin
      r_csum <= '0;
    end else if (w_ld_hs) begin
      r_csum <= r_csum + ld_data;
    end
  end

  assign load_csum = r_csum;
`else
  assign load_csum = '0;
`endif

  assign fetch_rvalid = r_fetch_rvalid;
  assign fetch_rdata  = r_fetch_rdata;
  assign load_done    = r_load_done;
  assign load_cnt     = r_load_cnt;

endmodule
